// File: rtl/discharge_seq.sv
// rtl/discharge_seq.sv - discharge PWM parameter sequencer with validity check and result code
// Optional watchdog: define DISCHARGE_SEQ_TIMEOUT_EN to add the RUN timeout counter and register (addr 6).
module discharge_seq #(
   parameter int C_PWM_CNT_WIDTH    = 16,
   parameter int C_FRACTIONAL_WIDTH = 16,
   parameter int C_NUMBER_WIDTH     = 32,
   parameter int C_TIMEOUT_WIDTH    = 32
) (
   input  logic                                        clk,
   input  logic                                        resetn,
   input  logic                                        cfg_wr,
   input  logic [2:0]                                  cfg_addr,
   input  logic [31:0]                                 cfg_wdata,
   input  logic                                        start,
   input  logic                                        abort,
   input  logic                                        pwm_done,
   output logic                                        pwm_resetn,
   output logic [C_PWM_CNT_WIDTH-1:0]                  denominator,
   output logic [C_PWM_CNT_WIDTH-1:0]                  numerator0,
   output logic [C_PWM_CNT_WIDTH-1:0]                  numerator1,
   output logic [C_NUMBER_WIDTH-1:0]                   number0,
   output logic [C_NUMBER_WIDTH-1:0]                   number1,
   output logic [C_PWM_CNT_WIDTH+C_FRACTIONAL_WIDTH-1:0] inc0,
   output logic                                        busy,
   output logic                                        done,
   output logic [1:0]                                  err
);

   localparam int INC_W = C_PWM_CNT_WIDTH + C_FRACTIONAL_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN} state_t;

   state_t                      state;
   logic [C_PWM_CNT_WIDTH-1:0]  sh_denominator;
   logic [C_PWM_CNT_WIDTH-1:0]  sh_numerator0;
   logic [C_PWM_CNT_WIDTH-1:0]  sh_numerator1;
   logic [C_NUMBER_WIDTH-1:0]   sh_number0;
   logic [C_NUMBER_WIDTH-1:0]   sh_number1;
   logic [INC_W-1:0]            sh_inc0;
   logic                        params_valid;

`ifdef DISCHARGE_SEQ_TIMEOUT_EN
   logic [C_TIMEOUT_WIDTH-1:0]  sh_timeout;
   logic [C_TIMEOUT_WIDTH-1:0]  act_timeout;
   logic [C_TIMEOUT_WIDTH-1:0]  tmo_cnt;
`endif

   // Judged on the active copy, so shadow writes during CHECK cannot affect the verdict.
   assign params_valid = (denominator >= C_PWM_CNT_WIDTH'(3)) &&
                         (numerator0 <= denominator) &&
                         (numerator1 <= numerator0) &&
                         (inc0 != '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= S_IDLE;
         sh_denominator <= '0;
         sh_numerator0  <= '0;
         sh_numerator1  <= '0;
         sh_number0     <= '0;
         sh_number1     <= '0;
         sh_inc0        <= '0;
         denominator    <= '0;
         numerator0     <= '0;
         numerator1     <= '0;
         number0        <= '0;
         number1        <= '0;
         inc0           <= '0;
         pwm_resetn     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 2'd0;
`ifdef DISCHARGE_SEQ_TIMEOUT_EN
         sh_timeout     <= '0;
         act_timeout    <= '0;
         tmo_cnt        <= '0;
`endif
      end else begin
         done <= 1'b0;

         // Non-blocking semantics let a same-cycle start copy the pre-write shadow value.
         if (cfg_wr) begin
            case (cfg_addr)
               3'd0: sh_denominator <= C_PWM_CNT_WIDTH'(cfg_wdata);
               3'd1: sh_numerator0  <= C_PWM_CNT_WIDTH'(cfg_wdata);
               3'd2: sh_numerator1  <= C_PWM_CNT_WIDTH'(cfg_wdata);
               3'd3: sh_number0     <= C_NUMBER_WIDTH'(cfg_wdata);
               3'd4: sh_number1     <= C_NUMBER_WIDTH'(cfg_wdata);
               3'd5: sh_inc0        <= INC_W'(cfg_wdata);
`ifdef DISCHARGE_SEQ_TIMEOUT_EN
               3'd6: sh_timeout     <= C_TIMEOUT_WIDTH'(cfg_wdata);
`endif
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  denominator <= sh_denominator;
                  numerator0  <= sh_numerator0;
                  numerator1  <= sh_numerator1;
                  number0     <= sh_number0;
                  number1     <= sh_number1;
                  inc0        <= sh_inc0;
`ifdef DISCHARGE_SEQ_TIMEOUT_EN
                  act_timeout <= sh_timeout;
`endif
                  err         <= 2'd0;
                  busy        <= 1'b1;
                  state       <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (abort || !params_valid) begin
                  err   <= abort ? 2'd2 : 2'd1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  pwm_resetn <= 1'b1;
                  state      <= S_RUN;
`ifdef DISCHARGE_SEQ_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end
            end
            S_RUN: begin
               if (pwm_done || abort) begin
                  err        <= pwm_done ? 2'd0 : 2'd2;
                  pwm_resetn <= 1'b0;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
`ifdef DISCHARGE_SEQ_TIMEOUT_EN
               else if ((act_timeout != '0) && (tmo_cnt == act_timeout)) begin
                  err        <= 2'd3;
                  pwm_resetn <= 1'b0;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/discharge_seq.md
DISCHARGE_SEQ -- requirements
Module: discharge_seq

Interface
REQ-001 SHALL provide parameter C_PWM_CNT_WIDTH, default 16, PWM counter/numerator width.
REQ-002 SHALL provide parameter C_FRACTIONAL_WIDTH, default 16, fractional bits of inc0.
REQ-003 SHALL provide parameter C_NUMBER_WIDTH, default 32, period-count width.
REQ-004 SHALL provide parameter C_TIMEOUT_WIDTH, default 32, watchdog counter width.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cfg_wr  in  1  single-cycle register write strobe.
REQ-008 SHALL have port cfg_addr  in  3  register select.
REQ-009 SHALL have port cfg_wdata  in  32  write data, LSB-aligned, truncated to the target width.
REQ-010 SHALL have port start  in  1  start request.
REQ-011 SHALL have port abort  in  1  abort request.
REQ-012 SHALL have port pwm_done  in  1  completion flag from the downstream discharge PWM controller.
REQ-013 SHALL have port pwm_resetn  out  1  synchronous active-low reset to the PWM controller; low means held idle.
REQ-014 SHALL have ports denominator, numerator0, numerator1  out  C_PWM_CNT_WIDTH each  active PWM parameters.
REQ-015 SHALL have ports number0, number1  out  C_NUMBER_WIDTH each  active period counts.
REQ-016 SHALL have port inc0  out  C_PWM_CNT_WIDTH+C_FRACTIONAL_WIDTH  active ramp decrement.
REQ-017 SHALL have port busy  out  1  high in CHECK or RUN.
REQ-018 SHALL have port done  out  1  one-cycle pulse at the end of every accepted start.
REQ-019 SHALL have port err  out  2  result code: 0 ok, 1 invalid params, 2 aborted, 3 timeout.

Function
REQ-020 SHALL hold shadow registers at cfg_addr 0..6: denominator, numerator0, numerator1, number0, number1, inc0, timeout; addr 7 writes are ignored; writes are accepted in any state.
REQ-021 SHALL implement states IDLE, CHECK and RUN.
REQ-022 IDLE: start=1 SHALL copy all shadows to the active outputs, clear err and enter CHECK next cycle; a cfg_wr in the same cycle updates the shadow only, after the copy.
REQ-023 SHALL ignore start outside IDLE; the active outputs SHALL remain stable outside IDLE.
REQ-024 CHECK (1 cycle): the parameters SHALL be valid only if denominator>=3, numerator0<=denominator, numerator1<=numerator0 and inc0!=0.
REQ-025 CHECK with invalid parameters SHALL set err=1, pulse done and return to IDLE.
REQ-026 CHECK with valid parameters SHALL set pwm_resetn=1 and enter RUN; pwm_resetn rises 2 cycles after the start cycle.
REQ-027 RUN with pwm_done=1 SHALL drive pwm_resetn=0, pulse done with err=0 and enter IDLE, all on the cycle after pwm_done is sampled.
REQ-028 RUN with abort=1 (and pwm_done=0) SHALL drive pwm_resetn=0, set err=2, pulse done and enter IDLE; when both are high, pwm_done wins.
REQ-029 CHECK with abort=1 SHALL set err=2 and pulse done regardless of validity; abort in IDLE SHALL be ignored.
REQ-030 err SHALL hold its value until the next accepted start.
REQ-031 pwm_resetn SHALL be low in IDLE and CHECK; pwm_done SHALL be ignored outside RUN.

Reset
REQ-032 resetn=0 SHALL force IDLE and zero all shadow and active registers, pwm_resetn, busy, done and err.
REQ-033 resetn=0 mid-RUN SHALL drop pwm_resetn on the next clk edge with no done pulse.

Configuration
REQ-034 Macro DISCHARGE_SEQ_TIMEOUT_EN defined: in RUN, a C_TIMEOUT_WIDTH counter cleared on RUN entry SHALL increment each cycle; when count==timeout!=0 (and pwm_done=0 and abort=0), the block SHALL drop pwm_resetn, set err=3, pulse done and enter IDLE; timeout=0 disables the watchdog.
REQ-035 Macro undefined: no counter and no timeout register SHALL exist; addr 6 writes SHALL be ignored and err SHALL never be 3.

Verification
REQ-036 Write denominator=10, numerator0=8, numerator1=2, number0=2, number1=3, inc0=0x10000, then start -> busy=1, pwm_resetn high at start+2; pwm_done=1 -> next cycle pwm_resetn=0, done=1 for one cycle, err=0, busy=0.
REQ-037 denominator=2, start -> CHECK fails, err=1, done pulse at start+2, pwm_resetn never rises.
REQ-038 Valid params, abort and pwm_done asserted in the same RUN cycle -> err=0 (completion wins).
REQ-039 Valid params, abort in RUN -> err=2; a second start while busy is ignored; shadow writes during RUN do not change the outputs until the next start.
REQ-040 With DISCHARGE_SEQ_TIMEOUT_EN, timeout=100, pwm_done held 0 -> pwm_resetn drops and err=3 at RUN cycle 100; resetn=0 mid-RUN -> all outputs 0, no done pulse.
